// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect and decode hand-off.
// master = fetch stage side, slave = memory/branch/decoder side.
interface fetch_stage_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  imemReqValid;
    logic                  imemReqReady;
    logic [ADDR_WIDTH-1:0] imemReqAddr;
    logic                  imemRspValid;
    logic [31:0]           imemRspData;
    logic                  redirectValid;
    logic [ADDR_WIDTH-1:0] redirectAddr;
    logic                  decValid;
    logic                  decReady;
    logic [31:0]           decInsn;
    logic [ADDR_WIDTH-1:0] decPC;

    modport master (
        output imemReqValid, imemReqAddr, decValid, decInsn, decPC,
        input  imemReqReady, imemRspValid, imemRspData, redirectValid, redirectAddr, decReady
    );

    modport slave (
        input  imemReqValid, imemReqAddr, decValid, decInsn, decPC,
        output imemReqReady, imemRspValid, imemRspData, redirectValid, redirectAddr, decReady
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, issues word fetches, tracks in-flight responses
// and buffers {insn, pc} pairs for decode; redirects flush the queue and drop stale responses.
module fetch_stage #(
    parameter int unsigned              ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC    = '0,
    parameter int unsigned              QUEUE_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;

    // Pending-address FIFO: PC of every accepted request awaiting its response
    logic [ADDR_WIDTH-1:0] pend_q [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] pend_d [QUEUE_DEPTH];
    logic [PTR_W-1:0]      pend_wr_q, pend_wr_d;
    logic [PTR_W-1:0]      pend_rd_q, pend_rd_d;

    // Instruction queue towards decode
    logic [31:0]           q_insn_q [QUEUE_DEPTH];
    logic [31:0]           q_insn_d [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc_q   [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc_d   [QUEUE_DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;

    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      discard_q, discard_d;

    logic [SUM_W-1:0]      occupancy_c;
    logic                  req_valid_c;
    logic                  req_fire_c;
    logic                  rsp_ok_c;
    logic                  rsp_push_c;
    logic                  dec_valid_c;
    logic                  dec_fire_c;

    // Issue only while every accepted request is guaranteed a queue slot
    assign occupancy_c = SUM_W'(outstanding_q) + SUM_W'(count_q);
    assign req_valid_c = !rst && !bus.redirectValid && (occupancy_c < SUM_W'(QUEUE_DEPTH));
    assign req_fire_c  = req_valid_c && bus.imemReqReady;
    assign rsp_ok_c    = bus.imemRspValid && (outstanding_q != '0);
    assign rsp_push_c  = rsp_ok_c && (discard_q == '0) && !bus.redirectValid;
    assign dec_valid_c = (count_q != '0);
    assign dec_fire_c  = dec_valid_c && bus.decReady;

    assign bus.imemReqValid = req_valid_c;
    assign bus.imemReqAddr  = pc_q;
    assign bus.decValid     = dec_valid_c;
    assign bus.decInsn      = q_insn_q[head_q];
    assign bus.decPC        = q_pc_q[head_q];

    always_comb begin
        pc_d          = pc_q;
        pend_d        = pend_q;
        pend_wr_d     = pend_wr_q;
        pend_rd_d     = pend_rd_q;
        q_insn_d      = q_insn_q;
        q_pc_d        = q_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire_c) - CNT_W'(rsp_ok_c);

        if (req_fire_c) begin
            pend_d[pend_wr_q] = pc_q;
            pend_wr_d         = pend_wr_q + PTR_W'(1);
            pc_d              = pc_q + ADDR_WIDTH'(4);
        end

        if (rsp_ok_c) begin
            pend_rd_d = pend_rd_q + PTR_W'(1);
        end

        if (bus.redirectValid) begin
            // Everything still in flight after this cycle belongs to the old path
            pc_d      = bus.redirectAddr & ~ADDR_WIDTH'(3);
            count_d   = '0;
            head_d    = '0;
            tail_d    = '0;
            discard_d = outstanding_q - CNT_W'(rsp_ok_c);
        end else begin
            if (rsp_ok_c && (discard_q != '0)) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if (rsp_push_c) begin
                q_insn_d[tail_q] = bus.imemRspData;
                q_pc_d[tail_q]   = pend_q[pend_rd_q];
                tail_d           = tail_q + PTR_W'(1);
            end
            if (dec_fire_c) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(rsp_push_c) - CNT_W'(dec_fire_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            pend_wr_q     <= '0;
            pend_rd_q     <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                pend_q[i]   <= '0;
                q_insn_q[i] <= '0;
                q_pc_q[i]   <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            pend_q        <= pend_d;
            pend_wr_q     <= pend_wr_d;
            pend_rd_q     <= pend_rd_d;
            q_insn_q      <= q_insn_d;
            q_pc_q        <= q_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    a_occupancy: assert property (@(posedge clk) disable iff (rst)
        occupancy_c <= SUM_W'(QUEUE_DEPTH));

    a_discard: assert property (@(posedge clk) disable iff (rst)
        discard_q <= outstanding_q);

endmodule
